// File: rtl/uart_alu_pkg.sv
// Shared types for the UART-to-ALU path: opcodes, parser states and header size.
package uart_alu_pkg;

    typedef enum logic [7:0] {
        OP_ADD  = 8'h01,
        OP_MUL  = 8'h02,
        OP_DIV  = 8'h03,
        OP_ECHO = 8'hEC
    } opcode_e;

    typedef enum logic [2:0] {
        ST_OPCODE,
        ST_RSVD,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_PAYLOAD,
        ST_DRAIN
    } parser_state_e;

    localparam logic [15:0] HEADER_BYTES = 16'd4;

    function automatic logic isLegalOp(input logic [7:0] op);
        return (op == OP_ECHO) || (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/uart_pkt_parser.sv
// Byte-stream packet parser: 4-byte header, then little-endian 32-bit operand words.
// Optional feature: define UART_PKT_PARSER_ERR_CNT_EN to count rejected packets in err_cnt_o.
module uart_pkt_parser
    import uart_alu_pkg::*;
#(
    parameter logic [15:0] MAX_LEN = 16'd1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  s_axis_tdata_i,
    input  logic        s_axis_tvalid_i,
    output logic        s_axis_tready_o,
    output logic [7:0]  m_op_o,
    output logic [31:0] m_data_o,
    output logic        m_last_o,
    output logic        m_valid_o,
    input  logic        m_ready_i,
    output logic [7:0]  err_cnt_o
);

    parser_state_e state_q;
    logic [7:0]    op_q;
    logic [7:0]    lenLo_q;
    logic [15:0]   wordCnt_q;
    logic [15:0]   drainCnt_q;
    logic [1:0]    byteIdx_q;
    logic [23:0]   partial_q;
    logic [31:0]   data_q;
    logic          last_q;
    logic          valid_q;

    logic          byteHs;
    logic [15:0]   pktLen;
    logic [15:0]   bodyLen;
    logic          pktLegal;

    // Single-entry output register: a byte may enter whenever the slot is free or draining now.
    assign s_axis_tready_o = !valid_q || m_ready_i;
    assign byteHs          = s_axis_tvalid_i && s_axis_tready_o;

    assign pktLen   = {s_axis_tdata_i, lenLo_q};
    assign bodyLen  = (pktLen < HEADER_BYTES) ? 16'd0 : (pktLen - HEADER_BYTES);
    assign pktLegal = isLegalOp(op_q)
                   && (pktLen >= 16'd8)
                   && (pktLen[1:0] == 2'b00)
                   && (pktLen <= MAX_LEN)
                   && ((op_q != OP_DIV) || (pktLen == 16'd12));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_OPCODE;
            op_q       <= 8'd0;
            lenLo_q    <= 8'd0;
            wordCnt_q  <= 16'd0;
            drainCnt_q <= 16'd0;
            byteIdx_q  <= 2'd0;
            partial_q  <= 24'd0;
            data_q     <= 32'd0;
            last_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            if (valid_q && m_ready_i) begin
                valid_q <= 1'b0;
            end
            if (byteHs) begin
                unique case (state_q)
                    ST_OPCODE: begin
                        op_q    <= s_axis_tdata_i;
                        state_q <= ST_RSVD;
                    end
                    ST_RSVD: begin
                        state_q <= ST_LEN_LO;
                    end
                    ST_LEN_LO: begin
                        lenLo_q <= s_axis_tdata_i;
                        state_q <= ST_LEN_HI;
                    end
                    ST_LEN_HI: begin
                        if (pktLegal) begin
                            wordCnt_q <= bodyLen >> 2;
                            byteIdx_q <= 2'd0;
                            state_q   <= ST_PAYLOAD;
                        end else begin
                            drainCnt_q <= bodyLen;
                            state_q    <= (bodyLen == 16'd0) ? ST_OPCODE : ST_DRAIN;
                        end
                    end
                    ST_PAYLOAD: begin
                        byteIdx_q <= byteIdx_q + 2'd1;
                        if (byteIdx_q == 2'd3) begin
                            data_q    <= {s_axis_tdata_i, partial_q};
                            valid_q   <= 1'b1;
                            last_q    <= (wordCnt_q == 16'd1);
                            wordCnt_q <= wordCnt_q - 16'd1;
                            if (wordCnt_q == 16'd1) begin
                                state_q <= ST_OPCODE;
                            end
                        end else begin
                            partial_q <= {s_axis_tdata_i, partial_q[23:8]};
                        end
                    end
                    ST_DRAIN: begin
                        drainCnt_q <= drainCnt_q - 16'd1;
                        if (drainCnt_q == 16'd1) begin
                            state_q <= ST_OPCODE;
                        end
                    end
                    default: begin
                        state_q <= ST_OPCODE;
                    end
                endcase
            end
        end
    end

`ifdef UART_PKT_PARSER_ERR_CNT_EN
    logic [7:0] errCnt_q;

    // Rejections are counted once, at the length byte, and the count sticks at 0xFF.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            errCnt_q <= 8'd0;
        end else if (byteHs && (state_q == ST_LEN_HI) && !pktLegal && (errCnt_q != 8'hFF)) begin
            errCnt_q <= errCnt_q + 8'd1;
        end
    end

    assign err_cnt_o = errCnt_q;
`else
    assign err_cnt_o = 8'd0;
`endif

    assign m_op_o    = op_q;
    assign m_data_o  = data_q;
    assign m_last_o  = last_q;
    assign m_valid_o = valid_q;

endmodule
